dpram_arbiter: RTL and testbench

Sits in front of the two-port `DEPTH`x`WIDTH` RAM and shares it among `N_REQ` requesters. Each cycle it grants up to two requests, one per RAM port, in round-robin order. It registers the granted commands onto the RAM port pins and routes read data back to the originating requester. It never issues two accesses to the same address in one cycle when either access is a write.

---
 rtl/dpram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_dpram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_arbiter.sv
// Shares a two-port RAM among N_REQ requesters, granting up to two per cycle (round-robin, or
// fixed priority when DPRAM_ARB_FIXED_PRIO_EN is defined). Grant is same-cycle combinational,
// the RAM command is registered (T+1), and read data returns to the requester at T+2.
module dpram_arbiter #(
    parameter int N_REQ = 4,
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_we,
    input  logic [N_REQ*AW-1:0]    req_addr,
    input  logic [N_REQ*WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [N_REQ*WIDTH-1:0] rsp_data,
    output logic                   ram_w_en_a,
    output logic                   ram_w_en_b,
    output logic [AW-1:0]          ram_addr_a,
    output logic [AW-1:0]          ram_addr_b,
    output logic [WIDTH-1:0]       ram_data_in_a,
    output logic [WIDTH-1:0]       ram_data_in_b,
    input  logic [WIDTH-1:0]       ram_data_out_a,
    input  logic [WIDTH-1:0]       ram_data_out_b
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    function automatic logic [IW-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IW'(s);
    endfunction

    // Index 0 of every [1:0] array is RAM port A, index 1 is port B.
    logic [IW-1:0]           scan_base;
    logic [1:0]              found;
    logic [1:0][IW-1:0]      sel_idx;
    logic [1:0]              sel_we;
    logic [1:0][AW-1:0]      sel_addr;
    logic [1:0][WIDTH-1:0]   sel_wdat;
    logic                    conflict;
    logic [1:0]              port_vld;
    logic [1:0][WIDTH-1:0]   ram_dout;

    logic [1:0]              ram_w_en_q, ram_w_en_d;
    logic [1:0][AW-1:0]      ram_addr_q, ram_addr_d;
    logic [1:0][WIDTH-1:0]   ram_wdat_q, ram_wdat_d;
    logic [1:0]              s1_vld_q, s1_vld_d, s1_rd_q, s1_rd_d;
    logic [1:0]              s2_vld_q, s2_vld_d, s2_rd_q, s2_rd_d;
    logic [1:0][IW-1:0]      s1_id_q, s1_id_d, s2_id_q, s2_id_d;
    logic [N_REQ*WIDTH-1:0]  rsp_hold_q, rsp_hold_d;

`ifdef DPRAM_ARB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    logic [IW-1:0]           ptr_q, ptr_d;
    assign scan_base = ptr_q;
`endif

    assign ram_dout = {ram_data_out_b, ram_data_out_a};

    always_comb begin
        logic [IW-1:0] cand;
        found    = '0;
        sel_idx  = '0;
        cand     = '0;
        sel_we   = '0;
        sel_addr = '0;
        sel_wdat = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = wrap_idx(int'(scan_base), k);
            if (req[cand]) begin
                if (!found[0]) begin
                    found[0]   = 1'b1;
                    sel_idx[0] = cand;
                end else if (!found[1]) begin
                    found[1]   = 1'b1;
                    sel_idx[1] = cand;
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            sel_we[p]   = req_we[sel_idx[p]];
            sel_addr[p] = req_addr[int'(sel_idx[p])*AW +: AW];
            sel_wdat[p] = req_wdata[int'(sel_idx[p])*WIDTH +: WIDTH];
        end
        // Same address with a write involved: port B backs off and retries next cycle.
        conflict = found[1] && (sel_addr[0] == sel_addr[1]) && (sel_we[0] || sel_we[1]);
        port_vld = {found[1] & ~conflict, found[0]};
    end

    always_comb begin
        gnt        = '0;
        ram_w_en_d = '0;
        ram_addr_d = ram_addr_q;
        ram_wdat_d = ram_wdat_q;
        for (int p = 0; p < 2; p++) begin
            if (port_vld[p]) begin
                if (!rst) gnt[sel_idx[p]] = 1'b1;
                ram_w_en_d[p] = sel_we[p];
                ram_addr_d[p] = sel_addr[p];
                ram_wdat_d[p] = sel_wdat[p];
            end
        end
        s1_vld_d = port_vld;
        s1_rd_d  = ~sel_we;
        s1_id_d  = sel_idx;
        s2_vld_d = s1_vld_q;
        s2_rd_d  = s1_rd_q;
        s2_id_d  = s1_id_q;
`ifndef DPRAM_ARB_FIXED_PRIO_EN
        ptr_d = ptr_q;
        if (port_vld[1])      ptr_d = wrap_idx(int'(sel_idx[1]), 1);
        else if (port_vld[0]) ptr_d = wrap_idx(int'(sel_idx[0]), 1);
`endif
    end

    // Live RAM data is forwarded in the return cycle; the hold register keeps it afterwards.
    always_comb begin
        rsp_valid  = '0;
        rsp_data   = rsp_hold_q;
        rsp_hold_d = rsp_hold_q;
        for (int p = 0; p < 2; p++) begin
            if (!rst && s2_vld_q[p] && s2_rd_q[p]) begin
                rsp_valid[s2_id_q[p]]                          = 1'b1;
                rsp_data[int'(s2_id_q[p])*WIDTH +: WIDTH]      = ram_dout[p];
                rsp_hold_d[int'(s2_id_q[p])*WIDTH +: WIDTH]    = ram_dout[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_w_en_q <= '0;
            ram_addr_q <= '0;
            ram_wdat_q <= '0;
            s1_vld_q   <= '0;
            s1_rd_q    <= '0;
            s1_id_q    <= '0;
            s2_vld_q   <= '0;
            s2_rd_q    <= '0;
            s2_id_q    <= '0;
            rsp_hold_q <= '0;
`ifndef DPRAM_ARB_FIXED_PRIO_EN
            ptr_q      <= '0;
`endif
        end else begin
            ram_w_en_q <= ram_w_en_d;
            ram_addr_q <= ram_addr_d;
            ram_wdat_q <= ram_wdat_d;
            s1_vld_q   <= s1_vld_d;
            s1_rd_q    <= s1_rd_d;
            s1_id_q    <= s1_id_d;
            s2_vld_q   <= s2_vld_d;
            s2_rd_q    <= s2_rd_d;
            s2_id_q    <= s2_id_d;
            rsp_hold_q <= rsp_hold_d;
`ifndef DPRAM_ARB_FIXED_PRIO_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign ram_w_en_a    = ram_w_en_q[0];
    assign ram_w_en_b    = ram_w_en_q[1];
    assign ram_addr_a    = ram_addr_q[0];
    assign ram_addr_b    = ram_addr_q[1];
    assign ram_data_in_a = ram_wdat_q[0];
    assign ram_data_in_b = ram_wdat_q[1];

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: directed scenarios plus random traffic against a queue-based reference
// model; expected read responses are queued at grant time and popped by an independent monitor.
module tb_dpram_arbiter;
    localparam int N  = 4;
    localparam int AW = 3;
    localparam int W  = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0, req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*W-1:0] req_wdata = '0;
    logic [N-1:0]   gnt, rsp_valid;
    logic [N*W-1:0] rsp_data;
    logic           ram_w_en_a, ram_w_en_b;
    logic [AW-1:0]  ram_addr_a, ram_addr_b;
    logic [W-1:0]   ram_data_in_a, ram_data_in_b;
    logic [W-1:0]   ram_data_out_a = '0, ram_data_out_b = '0;

    dpram_arbiter #(.N_REQ(N), .DEPTH(8), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ram_w_en_a(ram_w_en_a), .ram_w_en_b(ram_w_en_b),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_data_in_a(ram_data_in_a), .ram_data_in_b(ram_data_in_b),
        .ram_data_out_a(ram_data_out_a), .ram_data_out_b(ram_data_out_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Two-port RAM with registered read data
    logic [W-1:0] ram_mem [8];
    always @(posedge clk) begin
        if (ram_w_en_a) ram_mem[ram_addr_a] <= ram_data_in_a;
        if (ram_w_en_b) ram_mem[ram_addr_b] <= ram_data_in_b;
        ram_data_out_a <= ram_mem[ram_addr_a];
        ram_data_out_b <= ram_mem[ram_addr_b];
    end

    typedef struct { int id; int due; logic [W-1:0] data; } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    bit           pend [N];
    bit           pwe  [N];
    logic [AW-1:0] paddr [N];
    logic [W-1:0] pdat [N];
    int           waitc [N];
    bit           rst_drv = 1'b1;
    int           m_ptr = 0;
    logic [W-1:0] m_mem [8];
    bit           mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic issue(input int i, input bit we, input logic [AW-1:0] a, input logic [W-1:0] d);
        pend[i] = 1'b1; pwe[i] = we; paddr[i] = a; pdat[i] = d;
    endtask

    // One clock: drive inputs, sample the combinational grant, advance the reference model.
    task automatic step(output logic [N-1:0] g);
        logic [N-1:0] eg;
        int a, b, base, idx;
        exp_t e;
        @(posedge clk);
        #1;
        rst = rst_drv;
        for (int i = 0; i < N; i++) begin
            req[i]               = pend[i];
            req_we[i]            = pwe[i];
            req_addr[i*AW +: AW] = paddr[i];
            req_wdata[i*W +: W]  = pdat[i];
        end
        #1;
        g  = gnt;
        eg = '0;
        a  = -1;
        b  = -1;
        if (rst_drv) begin
            exp_q.delete();
            m_ptr = 0;
            for (int i = 0; i < N; i++) waitc[i] = 0;
        end else begin
`ifdef DPRAM_ARB_FIXED_PRIO_EN
            base = 0;
`else
            base = m_ptr;
`endif
            for (int k = 0; k < N; k++) begin
                idx = (base + k) % N;
                if (pend[idx]) begin
                    if (a < 0) a = idx;
                    else if (b < 0) b = idx;
                end
            end
            if (b >= 0 && paddr[a] == paddr[b] && (pwe[a] || pwe[b])) b = -1;
            if (a >= 0) eg[a] = 1'b1;
            if (b >= 0) eg[b] = 1'b1;
            for (int i = 0; i < N; i++)
                if (eg[i] && !pwe[i]) begin
                    e.id = i; e.due = cyc + 2; e.data = m_mem[paddr[i]];
                    exp_q.push_back(e);
                end
            for (int i = 0; i < N; i++)
                if (eg[i] && pwe[i]) m_mem[paddr[i]] = pdat[i];
            if (b >= 0)      m_ptr = (b + 1) % N;
            else if (a >= 0) m_ptr = (a + 1) % N;
            for (int i = 0; i < N; i++) begin
                if (pend[i]) waitc[i]++;
`ifndef DPRAM_ARB_FIXED_PRIO_EN
                if (eg[i]) begin
                    tests++;
                    if (waitc[i] > N) begin
                        fails++;
                        $display("FAIL fairness: req %0d waited %0d cycles, limit %0d", i, waitc[i], N);
                    end
                end
`endif
                if (eg[i]) begin pend[i] = 1'b0; waitc[i] = 0; end
            end
        end
        chk("gnt", 32'(g), 32'(eg));
    endtask

    task automatic idle(input int n);
        logic [N-1:0] g;
        repeat (n) step(g);
    endtask

    task automatic do_reset();
        logic [N-1:0] g;
        rst_drv = 1'b1;
        step(g);
        rst_drv = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_w_en", {ram_w_en_b, ram_w_en_a}, 0);
        chk("rst_addr", {ram_addr_b, ram_addr_a}, 0);
        chk("rst_data_in", {ram_data_in_b, ram_data_in_a}, 0);
    endtask

    // Monitor: pops expected responses as the DUT presents them.
    logic [W-1:0] last_d [N];
    bit rst_prev = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < N; i++) if (rst_prev) last_d[i] = '0;
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i]) begin
                    int f;
                    f = -1;
                    for (int q = 0; q < exp_q.size(); q++)
                        if (f < 0 && exp_q[q].id == i) f = q;
                    if (f < 0) begin
                        tests++; fails++;
                        $display("FAIL rsp_unexpected: req %0d data %0h, no read outstanding", i, rsp_data[i*W +: W]);
                    end else begin
                        chk("rsp_cycle", exp_q[f].due, cyc);
                        chk("rsp_data", rsp_data[i*W +: W], exp_q[f].data);
                        exp_q.delete(f);
                    end
                    last_d[i] = rsp_data[i*W +: W];
                end else begin
                    chk("rsp_hold", rsp_data[i*W +: W], last_d[i]);
                end
            end
            tests++;
            for (int q = exp_q.size() - 1; q >= 0; q--)
                if (exp_q[q].due <= cyc) begin
                    fails++;
                    $display("FAIL rsp_missing: req %0d due cycle %0d, expected data %0h", exp_q[q].id, exp_q[q].due, exp_q[q].data);
                    exp_q.delete(q);
                end
            rst_prev = rst;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] pat [4];
        for (int i = 0; i < 8; i++) begin ram_mem[i] = '0; m_mem[i] = '0; end
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; pwe[i] = 0; paddr[i] = '0; pdat[i] = '0; waitc[i] = 0; last_d[i] = '0;
        end

        // Reset then idle, then a mid-stream reset
        rst_drv = 1'b1;
        step(g);
        step(g);
        rst_drv = 1'b0;
        chk_reset_vals();
        mon_en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(g);
            chk("idle_w_en", {ram_w_en_b, ram_w_en_a}, 0);
        end
        do_reset();
        step(g);
        chk_reset_vals();

        // Write 0xA5 to addr 3, read it back one cycle later
        do_reset();
        issue(0, 1, 3, 8'hA5);
        step(g); chk("wr_then_rd_gnt0", 32'(g), 32'h1);
        issue(1, 0, 3, 8'h00);
        step(g); chk("wr_then_rd_gnt1", 32'(g), 32'h2);
        idle(4);

        // Two parallel reads on both ports
        do_reset();
        issue(0, 1, 1, 8'h11);
        issue(1, 1, 6, 8'h66);
        step(g); chk("dual_wr_gnt", 32'(g), 32'h3);
        idle(3);
        do_reset();
        issue(0, 0, 1, 8'h00);
        issue(2, 0, 6, 8'h00);
        step(g); chk("dual_rd_gnt", 32'(g), 32'h5);
        idle(4);

        // Write/read address conflict: read deferred one cycle and sees new data
        do_reset();
        issue(0, 1, 5, 8'h5A);
        issue(1, 0, 5, 8'h00);
        step(g); chk("conflict_gnt0", 32'(g), 32'h1);
        step(g); chk("conflict_gnt1", 32'(g), 32'h2);
        idle(4);

        // All four requesting continuously
`ifdef DPRAM_ARB_FIXED_PRIO_EN
        pat[0] = 4'b0011; pat[1] = 4'b0011; pat[2] = 4'b0011; pat[3] = 4'b0011;
`else
        pat[0] = 4'b0011; pat[1] = 4'b1100; pat[2] = 4'b0011; pat[3] = 4'b1100;
`endif
        do_reset();
        for (int i = 0; i < N; i++) issue(i, 0, AW'($urandom_range(0, 7)), 8'h00);
        for (int c = 0; c < 4; c++) begin
            step(g);
            chk("all_req_gnt", 32'(g), 32'(pat[c]));
            for (int i = 0; i < N; i++) if (!pend[i]) issue(i, 0, AW'($urandom_range(0, 7)), 8'h00);
        end
        idle(8);

        // Reset one cycle after a read grant drops the response and clears the pointer
        do_reset();
        issue(2, 0, 6, 8'h00);
        step(g); chk("rst_rd_gnt", 32'(g), 32'h4);
        do_reset();
        for (int i = 0; i < N; i++) issue(i, 0, AW'(i), 8'h00);
        step(g);
        chk("rst_rd_no_rsp0", 32'(rsp_valid), 0);
        chk("rst_addr_cleared", {ram_addr_b, ram_addr_a}, 0);
        chk("rst_ptr_zero_gnt", 32'(g), 32'h3);
        step(g);
        chk("rst_rd_no_rsp1", 32'(rsp_valid), 0);
        idle(6);

        // Random traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            rst_drv = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    issue(i, bit'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), W'($urandom_range(0, 255)));
            step(g);
        end
        rst_drv = 1'b0;
        idle(12);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
